mem_responder: RTL and testbench

//  Target end of the byte-wide RAM bus driven by the memory controller (r_or_w/a_in/d_in/d_out).

---
 rtl/mem_map_pkg.sv | 12 +
 rtl/byte_fifo.sv | 40 ++++
 rtl/mem_responder.sv | 85 ++++++++
 tb/tb_mem_responder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mem_map_pkg.sv
// mem_map_pkg: I/O window decode constants and status byte layout for mem_responder.
package mem_map_pkg;
  localparam logic [1:0] IO_SEL      = 2'b11;
  localparam logic [2:0] IO_DATA_OFS = 3'd0;
  localparam logic [2:0] IO_CTRL_OFS = 3'd4;
  localparam int         ST_FULL_BIT = 0;
  localparam int         ST_RXNE_BIT = 1;
  typedef enum logic [1:0] {SEL_RAM, SEL_DATA, SEL_CTRL, SEL_NONE} sel_e;
  function automatic sel_e decode(input logic [1:0] win, input logic [2:0] ofs);
    return win != IO_SEL ? SEL_RAM : ofs == IO_DATA_OFS ? SEL_DATA : ofs == IO_CTRL_OFS ? SEL_CTRL : SEL_NONE;
  endfunction
endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: power-of-2 byte FIFO; a pop in the same cycle frees the slot for a push when full.
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic do_push, do_pop;
  assign full    = count == FULL_CNT;
  assign empty   = count == '0;
  assign dout    = mem[rd_ptr];
  assign do_pop  = en & pop & ~empty;
  assign do_push = en & push & (~full | do_pop);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: byte RAM target with 1-cycle reads plus TX/RX FIFO, status and halt I/O window.
// Optional RX FIFO enabled by defining IO_RX_EN.
module mem_responder
  import mem_map_pkg::*;
#(
  parameter int ADDR_WIDTH = 17,
  parameter int TX_DEPTH   = 8,
  parameter int RX_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic        r_or_w,
  input  logic [31:0] a_in,
  input  logic [7:0]  d_in,
  output logic [7:0]  d_out,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        halt
);
  localparam int TW = $clog2(TX_DEPTH) + 1;
  logic [7:0] mem [2**ADDR_WIDTH];
  sel_e sel;
  logic [ADDR_WIDTH-1:0] idx;
  logic [TW-1:0] tx_count;
  logic tx_full, tx_empty, tx_push, tx_pop;
  logic [7:0] tx_drop_cnt, rx_head, status, rd_data;
  logic rx_nonempty;
  logic unused_hi, unused_rx;
  assign sel       = decode(a_in[17:16], a_in[2:0]);
  assign idx       = a_in[ADDR_WIDTH-1:0];
  assign unused_hi = ^{a_in[31:18], tx_drop_cnt};
  assign tx_push   = r_or_w & (sel == SEL_DATA);
  assign tx_pop    = tx_valid & tx_ready;
  assign tx_valid  = ~tx_empty;
  assign io_buffer_full = tx_count >= TW'(TX_DEPTH - 2);
  byte_fifo #(.DEPTH(TX_DEPTH)) u_tx (
    .clk, .rst_n, .en(rdy), .push(tx_push), .pop(tx_pop), .din(d_in),
    .dout(tx_data), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );
`ifdef IO_RX_EN
  logic rx_full, rx_empty, rx_pop;
  logic [$clog2(RX_DEPTH):0] rx_count;
  assign rx_pop      = ~r_or_w & (sel == SEL_DATA);
  assign rx_ready    = ~rx_full;
  assign rx_nonempty = ~rx_empty;
  assign unused_rx   = ^rx_count;
  byte_fifo #(.DEPTH(RX_DEPTH)) u_rx (
    .clk, .rst_n, .en(rdy), .push(rx_valid & rx_ready), .pop(rx_pop), .din(rx_data),
    .dout(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );
`else
  assign rx_ready    = 1'b0;
  assign rx_head     = 8'h00;
  assign rx_nonempty = 1'b0;
  assign unused_rx   = ^{rx_data, rx_valid};
`endif
  always_comb begin
    status = 8'h00;
    status[ST_FULL_BIT] = io_buffer_full;
    status[ST_RXNE_BIT] = rx_nonempty;
    rd_data = sel == SEL_RAM  ? mem[idx] :
              sel == SEL_DATA ? (rx_nonempty ? rx_head : 8'h00) :
              sel == SEL_CTRL ? status : 8'h00;
  end
  always_ff @(posedge clk) begin
    if (rst_n && rdy && r_or_w && sel == SEL_RAM) mem[idx] <= d_in;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_out       <= 8'h00;
      halt        <= 1'b0;
      tx_drop_cnt <= 8'h00;
    end else if (rdy) begin
      if (!r_or_w) d_out <= rd_data;
      if (r_or_w && sel == SEL_CTRL) halt <= 1'b1;
      if (tx_push && tx_full && !tx_pop && tx_drop_cnt != 8'hFF) tx_drop_cnt <= tx_drop_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed + randomized bench against a queue/array reference model.
module tb_mem_responder;
  localparam int TX_DEPTH = 8;
  localparam int RX_DEPTH = 8;
`ifdef IO_RX_EN
  localparam bit RXEN = 1'b1;
`else
  localparam bit RXEN = 1'b0;
`endif
  localparam logic [31:0] IDLE = 32'h0003_0001;
  logic clk = 1'b0;
  logic rst_n, rdy, r_or_w, tx_ready, rx_valid;
  logic [31:0] a_in;
  logic [7:0] d_in, rx_data, d_out, tx_data;
  logic io_buffer_full, tx_valid, rx_ready, halt;
  int n_pass = 0, n_total = 0;

  mem_responder dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .r_or_w(r_or_w), .a_in(a_in), .d_in(d_in),
    .d_out(d_out), .io_buffer_full(io_buffer_full), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .halt(halt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h at %0t", name, got, exp, $time);
  endtask

  // reference model
  logic [7:0] mem_m [int];
  logic [7:0] txq[$], rxq[$];
  logic [7:0] ex_dout, ex_drop;
  logic ex_halt, dknown, mvalid = 1'b0;

  always @(posedge clk) begin
    logic io, tx_pop, rx_push;
    logic [2:0] ofs;
    logic [7:0] st;
    int key;
    if (!rst_n) begin
      ex_dout = 8'h00; ex_halt = 1'b0; ex_drop = 8'h00;
      txq.delete(); rxq.delete();
      dknown = 1'b1; mvalid = 1'b1;
    end else if (rdy && mvalid) begin
      io = a_in[17:16] == 2'b11;
      ofs = a_in[2:0];
      key = int'(a_in[16:0]);
      tx_pop = txq.size() > 0 && tx_ready;
      rx_push = RXEN && rx_valid && rxq.size() < RX_DEPTH;
      st = {6'b0, rxq.size() > 0, txq.size() >= TX_DEPTH - 2};
      if (tx_pop) void'(txq.pop_front());
      if (r_or_w) begin
        if (!io) mem_m[key] = d_in;
        else if (ofs == 3'd0) begin
          if (txq.size() < TX_DEPTH) txq.push_back(d_in);
          else if (ex_drop != 8'hFF) ex_drop = ex_drop + 8'd1;
        end else if (ofs == 3'd4) ex_halt = 1'b1;
      end else begin
        dknown = 1'b1;
        if (!io) begin
          if (mem_m.exists(key)) ex_dout = mem_m[key];
          else dknown = 1'b0;
        end else if (ofs == 3'd0) begin
          if (rxq.size() > 0) ex_dout = rxq.pop_front();
          else ex_dout = 8'h00;
        end else if (ofs == 3'd4) ex_dout = st;
        else ex_dout = 8'h00;
      end
      if (rx_push) rxq.push_back(rx_data);
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("tx_valid", {7'b0, tx_valid}, {7'b0, txq.size() > 0});
      if (txq.size() > 0) chk("tx_data", tx_data, txq[0]);
      chk("io_buffer_full", {7'b0, io_buffer_full}, {7'b0, txq.size() >= TX_DEPTH - 2});
      chk("rx_ready", {7'b0, rx_ready}, {7'b0, RXEN && rxq.size() < RX_DEPTH});
      chk("halt", {7'b0, halt}, {7'b0, ex_halt});
      chk("tx_drop_cnt", dut.tx_drop_cnt, ex_drop);
      if (dknown) chk("d_out", d_out, ex_dout);
    end
  end

  task automatic cyc(input logic w, input logic [31:0] a, input logic [7:0] d);
    r_or_w = w; a_in = a; d_in = d;
    @(negedge clk);
  endtask

  function automatic logic [31:0] pool_addr();
    logic [31:0] a;
    int i;
    i = $urandom_range(0, 127);
    a = $urandom;
    a[16:0] = i < 64 ? 17'(i) : 17'(32'h1FFC0 + i - 64);
    if (i >= 64) a[17] = 1'b0;
    return a;
  endfunction

  initial begin
    logic [7:0] drain_exp [8];
    logic [31:0] a;
    int k;
    drain_exp = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hEE};
    rst_n = 1'b0; rdy = 1'b1; r_or_w = 1'b0; a_in = IDLE; d_in = 8'h00;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    @(negedge clk);
    cyc(0, IDLE, 0);
    chk("rst d_out", d_out, 8'h00);
    chk("rst halt", {7'b0, halt}, 8'h00);
    chk("rst tx_valid", {7'b0, tx_valid}, 8'h00);
    chk("rst io_buffer_full", {7'b0, io_buffer_full}, 8'h00);
    chk("rst rx_ready", {7'b0, rx_ready}, {7'b0, RXEN});
    rst_n = 1'b1;
    cyc(1, 32'h10, 8'hA5);
    cyc(0, 32'h10, 8'h00);
    chk("ram A5", d_out, 8'hA5);
    for (int i = 0; i < 4; i++) cyc(1, 32'h20 + i, 8'((i + 1) * 8'h11));
    for (int i = 0; i < 4; i++) begin
      cyc(0, 32'h20 + i, 8'h00);
      chk("ram seq", d_out, 8'((i + 1) * 8'h11));
    end
    for (int i = 1; i <= 10; i++) begin
      cyc(1, 32'h30000, 8'(i));
      if (i == 5) chk("ibf after 5", {7'b0, io_buffer_full}, 8'h00);
      if (i == 6) chk("ibf after 6", {7'b0, io_buffer_full}, 8'h01);
    end
    chk("drop after 10", dut.tx_drop_cnt, 8'h02);
    chk("tx head", tx_data, 8'h01);
    tx_ready = 1'b1;
    cyc(1, 32'h30000, 8'hEE);
    tx_ready = 1'b0;
    chk("full push+pop head", tx_data, 8'h02);
    chk("full push+pop drop", dut.tx_drop_cnt, 8'h02);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain order", tx_data, drain_exp[i]);
      cyc(0, IDLE, 0);
    end
    tx_ready = 1'b0;
    chk("drained", {7'b0, tx_valid}, 8'h00);
    cyc(1, 32'h30004, 8'h77);
    chk("halt set", {7'b0, halt}, 8'h01);
    cyc(1, 32'h30000, 8'h99);
    rst_n = 1'b0;
    cyc(0, IDLE, 0);
    rst_n = 1'b1;
    chk("halt cleared", {7'b0, halt}, 8'h00);
    chk("tx cleared", {7'b0, tx_valid}, 8'h00);
    cyc(0, 32'h10, 8'h00);
    chk("ram kept", d_out, 8'hA5);
    rdy = 1'b0;
    cyc(0, 32'h20, 8'h00);
    chk("rdy freeze", d_out, 8'hA5);
    rdy = 1'b1;
`ifdef IO_RX_EN
    rx_data = 8'h5A; rx_valid = 1'b1;
    cyc(0, IDLE, 0);
    rx_valid = 1'b0;
    cyc(0, 32'h30004, 0);
    chk("rx status", d_out, 8'h02);
    cyc(0, 32'h30000, 0);
    chk("rx pop", d_out, 8'h5A);
    cyc(0, 32'h30000, 0);
    chk("rx empty", d_out, 8'h00);
`else
    cyc(0, 32'h30000, 0);
    chk("no rx data", d_out, 8'h00);
    cyc(0, 32'h30004, 0);
    chk("no rx status", d_out, 8'h00);
`endif
    for (int i = 0; i < 128; i++) begin
      a = pool_addr();
      cyc(1, a, 8'($urandom));
    end
    for (int i = 0; i < 3000; i++) begin
      rst_n = $urandom_range(0, 199) != 0;
      rdy = $urandom_range(0, 4) != 0;
      tx_ready = $urandom_range(0, 1) == 1;
      rx_valid = $urandom_range(0, 2) == 0;
      rx_data = 8'($urandom);
      k = $urandom_range(0, 9);
      if (k < 5) a = pool_addr();
      else begin
        a = $urandom;
        a[17:16] = 2'b11;
        a[2:0] = k < 7 ? 3'd0 : k < 9 ? 3'd4 : 3'($urandom_range(1, 3) + ($urandom_range(0, 1) * 4));
      end
      cyc(k == 7 || k == 8 ? ($urandom_range(0, 7) == 0) : 1'($urandom_range(0, 1)), a, 8'($urandom));
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
